// File: rtl/stream_mux_2to1_4bit.sv
// Two-source stream mux with a registered output stage and a fairness arbiter
// that caps an owner at HOLD consecutive beats while the other source waits.
module stream_mux_2to1_4bit #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a_data,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [3:0] b_data,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [3:0] out_data,
  output logic       out_src,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;
  localparam logic [3:0] HOLD_C   = 4'(HOLD);

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic       r_last;       // 0 = A, 1 = B
  logic [3:0] r_out_data;
  logic       r_out_src;
  logic       r_out_valid;

  logic w_load;
  logic w_req;
  logic w_pick_b;
  logic w_gnt;
  logic w_same_owner;

  assign w_load = ~r_out_valid | out_ready;

  // Pick a source purely from valids and arbiter state; ready never feeds back into valid.
  always_comb begin
    w_req    = 1'b0;
    w_pick_b = 1'b0;
    case (r_state)
      ST_OWN_A: begin
        if (a_valid && ((r_cnt < HOLD_C) || !b_valid)) begin
          w_req = 1'b1;
        end else if (b_valid) begin
          w_req    = 1'b1;
          w_pick_b = 1'b1;
        end
      end
      ST_OWN_B: begin
        if (b_valid && ((r_cnt < HOLD_C) || !a_valid)) begin
          w_req    = 1'b1;
          w_pick_b = 1'b1;
        end else if (a_valid) begin
          w_req = 1'b1;
        end
      end
      default: begin
        if (a_valid && b_valid) begin
          w_req    = 1'b1;
          w_pick_b = ~r_last;
        end else if (a_valid) begin
          w_req = 1'b1;
        end else if (b_valid) begin
          w_req    = 1'b1;
          w_pick_b = 1'b1;
        end
      end
    endcase
  end

  assign w_gnt        = w_req & w_load & rst_n;
  assign w_same_owner = w_pick_b ? (r_state == ST_OWN_B) : (r_state == ST_OWN_A);

  assign a_ready = w_gnt & ~w_pick_b;
  assign b_ready = w_gnt &  w_pick_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_last      <= 1'b1;
      r_out_data  <= 4'h0;
      r_out_src   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_gnt) begin
      r_state     <= w_pick_b ? ST_OWN_B : ST_OWN_A;
      r_last      <= w_pick_b;
      r_out_data  <= w_pick_b ? b_data : a_data;
      r_out_src   <= w_pick_b;
      r_out_valid <= 1'b1;
      if (w_same_owner) begin
        r_cnt <= (r_cnt == HOLD_C) ? r_cnt : r_cnt + 4'd1;
      end else begin
        r_cnt <= 4'd1;
      end
    end else if (w_load) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_2to1_4bit.sv
// Bench for stream_mux_2to1_4bit: HOLD=4 and HOLD=1 instances share stimulus,
// checked by a vector table, directed sequences and a randomized reference model.
module tb_stream_mux_2to1_4bit;

  logic       clk = 1'b0;
  logic       rst_n, a_valid, b_valid, out_ready;
  logic [3:0] a_data, b_data;
  logic [1:0] a_ready, b_ready, out_valid, out_src;
  logic [1:0][3:0] out_data;

  always #5 clk = ~clk;

  stream_mux_2to1_4bit #(.HOLD(4)) u_h4 (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready[0]),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready[0]),
    .out_data(out_data[0]), .out_src(out_src[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready)
  );

  stream_mux_2to1_4bit #(.HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready[1]),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready[1]),
    .out_data(out_data[1]), .out_src(out_src[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 none, 0 A, 1 B), run length, last winner, output word.
  int         hold_of [2] = '{4, 1};
  int         m_owner [2];
  int         m_run   [2];
  int         m_last  [2];
  int         m_valid [2];
  int         m_src   [2];
  logic [3:0] m_data  [2];
  bit         m_known = 1'b0;

  function automatic int pick(input int d);
    int own, xv, yv;
    if (!rst_n) return -1;
    if (m_valid[d] != 0 && !out_ready) return -1;
    if (m_owner[d] < 0) begin
      if (a_valid && b_valid) return 1 - m_last[d];
      if (a_valid) return 0;
      if (b_valid) return 1;
      return -1;
    end
    own = m_owner[d];
    xv  = (own == 1) ? int'(b_valid) : int'(a_valid);
    yv  = (own == 1) ? int'(a_valid) : int'(b_valid);
    if (xv != 0 && (m_run[d] < hold_of[d] || yv == 0)) return own;
    if (yv != 0) return 1 - own;
    return -1;
  endfunction

  task automatic drive(input bit r, input bit av, input logic [3:0] ad,
                       input bit bv, input logic [3:0] bd, input bit ordy);
    int g;
    rst_n = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    #3;
    if (m_known) begin
      for (int d = 0; d < 2; d++) begin
        g = pick(d);
        check($sformatf("h%0d_a_ready", hold_of[d]), int'(a_ready[d]), int'(g == 0));
        check($sformatf("h%0d_b_ready", hold_of[d]), int'(b_ready[d]), int'(g == 1));
        check($sformatf("h%0d_out_valid", hold_of[d]), int'(out_valid[d]), m_valid[d]);
        if (m_valid[d] != 0) begin
          check($sformatf("h%0d_out_data", hold_of[d]), int'(out_data[d]), int'(m_data[d]));
          check($sformatf("h%0d_out_src", hold_of[d]), int'(out_src[d]), m_src[d]);
        end
      end
    end
  endtask

  task automatic adv();
    int   g [2];
    bit   load [2];
    for (int d = 0; d < 2; d++) begin
      g[d]    = pick(d);
      load[d] = (m_valid[d] == 0) || out_ready;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_owner[d] = -1; m_run[d] = 0; m_last[d] = 1;
        m_valid[d] = 0;  m_src[d] = 0; m_data[d] = 4'h0;
      end else if (m_known && g[d] >= 0) begin
        m_run[d]   = (m_owner[d] == g[d]) ? ((m_run[d] < hold_of[d]) ? m_run[d] + 1 : m_run[d]) : 1;
        m_owner[d] = g[d];
        m_last[d]  = g[d];
        m_valid[d] = 1;
        m_src[d]   = g[d];
        m_data[d]  = (g[d] == 1) ? b_data : a_data;
      end else if (m_known && load[d]) begin
        m_owner[d] = -1; m_run[d] = 0; m_valid[d] = 0;
      end
    end
    if (!rst_n) m_known = 1'b1;
    #1;
  endtask

  typedef struct {
    bit rst; bit av; logic [3:0] ad; bit bv; logic [3:0] bd; bit ordy;
    bit ea; bit eb; bit ev; logic [3:0] ed; bit es; bit cd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int na, nb, ai, bi, esrc;
    logic [3:0] edat;

    tbl[0]  = '{0,1,4'h2,0,4'h0,1, 0,0,0,4'h0,0,1};
    tbl[1]  = '{0,1,4'h2,0,4'h0,1, 0,0,0,4'h0,0,1};
    tbl[2]  = '{1,1,4'h2,0,4'h0,1, 1,0,0,4'h0,0,1};
    tbl[3]  = '{1,0,4'h0,0,4'h0,1, 0,0,1,4'h2,0,1};
    tbl[4]  = '{1,0,4'h0,0,4'h0,1, 0,0,0,4'h0,0,0};
    tbl[5]  = '{1,1,4'h1,1,4'h9,1, 0,1,0,4'h0,0,0};
    tbl[6]  = '{1,1,4'h1,1,4'h9,0, 0,0,1,4'h9,1,1};
    tbl[7]  = '{1,1,4'h1,1,4'h9,0, 0,0,1,4'h9,1,1};
    tbl[8]  = '{1,1,4'h1,1,4'h9,0, 0,0,1,4'h9,1,1};
    tbl[9]  = '{1,1,4'h1,1,4'h5,1, 0,1,1,4'h9,1,1};
    tbl[10] = '{1,0,4'h0,0,4'h0,1, 0,0,1,4'h5,1,1};
    tbl[11] = '{1,1,4'h3,0,4'h0,1, 1,0,0,4'h0,0,0};
    tbl[12] = '{1,1,4'h3,1,4'h6,0, 0,0,1,4'h3,0,1};
    tbl[13] = '{0,1,4'h3,1,4'h6,0, 0,0,1,4'h3,0,1};
    tbl[14] = '{1,1,4'h4,1,4'h6,1, 1,0,0,4'h0,0,1};
    tbl[15] = '{1,0,4'h0,0,4'h0,1, 0,0,1,4'h4,0,1};

    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = 4'h0; b_data = 4'h0;
    @(posedge clk); #1;
    drive(0, 0, 4'h0, 0, 4'h0, 1); adv();

    // Vector table against the HOLD=4 instance.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].ordy);
      check($sformatf("vec%0d_a_ready", i), int'(a_ready[0]), int'(tbl[i].ea));
      check($sformatf("vec%0d_b_ready", i), int'(b_ready[0]), int'(tbl[i].eb));
      check($sformatf("vec%0d_out_valid", i), int'(out_valid[0]), int'(tbl[i].ev));
      if (tbl[i].cd) begin
        check($sformatf("vec%0d_out_data", i), int'(out_data[0]), int'(tbl[i].ed));
        check($sformatf("vec%0d_out_src", i), int'(out_src[0]), int'(tbl[i].es));
      end
      adv();
    end

    // Both sources saturated: HOLD=4 gives 4/4 runs, HOLD=1 alternates.
    drive(0, 0, 4'h0, 0, 4'h0, 1); adv();
    drive(0, 0, 4'h0, 0, 4'h0, 1); adv();
    na = 0; nb = 0; ai = 0; bi = 0;
    for (int s = 0; s < 14; s++) begin
      drive(1, 1, 4'(2 + ai % 7), 1, 4'(9 + bi % 7), 1);
      if (s >= 1) begin
        esrc = ((s - 1) / 4) % 2;
        if (esrc == 0) begin edat = 4'(2 + na % 7); na++; end
        else           begin edat = 4'(9 + nb % 7); nb++; end
        check($sformatf("rr_h4_src%0d", s), int'(out_src[0]), esrc);
        check($sformatf("rr_h4_data%0d", s), int'(out_data[0]), int'(edat));
        check($sformatf("rr_h1_src%0d", s), int'(out_src[1]), (s - 1) % 2);
      end
      if (a_ready[0]) ai++;
      if (b_ready[0]) bi++;
      adv();
    end

    // Owner A drops valid mid-run: B takes over in the same cycle.
    drive(0, 0, 4'h0, 0, 4'h0, 1); adv();
    drive(1, 1, 4'h1, 1, 4'h2, 1); adv();
    drive(1, 0, 4'h0, 1, 4'h2, 1);
    check("drop_h4_b_ready", int'(b_ready[0]), 1);
    check("drop_h1_b_ready", int'(b_ready[1]), 1);
    adv();
    drive(1, 0, 4'h0, 0, 4'h0, 1);
    check("drop_h4_src", int'(out_src[0]), 1);
    adv();

    // B streams alone for 10 beats, then a waiting A wins immediately.
    drive(0, 0, 4'h0, 0, 4'h0, 1); adv();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 4'h0, 1, 4'(i), 1);
      check($sformatf("solo_b_ready%0d", i), int'(b_ready[0]), 1);
      if (i > 0) check($sformatf("solo_b_data%0d", i), int'(out_data[0]), i - 1);
      adv();
    end
    drive(1, 1, 4'h7, 1, 4'hA, 1);
    check("solo_a_wins", int'(a_ready[0]), 1);
    check("solo_last_b", int'(out_data[0]), 9);
    adv();
    drive(1, 0, 4'h0, 0, 4'h0, 1);
    check("solo_next_src", int'(out_src[0]), 0);
    check("solo_next_data", int'(out_data[0]), 7);
    adv();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 40) != 0, ($urandom % 4) != 0, 4'($urandom),
            ($urandom % 3) != 0, 4'($urandom), ($urandom % 4) != 0);
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
